// File: rtl/cr_tlvp_ob_arb.sv
// Frame-aware round-robin arbiter sharing one TLV parser outbound write port among N_REQ FIFOs.
// Optional lock timeout is built when CR_TLVP_OB_ARB_LOCK_TMO_EN is defined.
module cr_tlvp_ob_arb #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned LOCK_TMO = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_vld_i,
    input  logic [N_REQ*DATA_W-1:0]   req_tlv_i,
    input  logic [N_REQ-1:0]          req_eot_i,
    output logic [N_REQ-1:0]          req_rd_o,
    output logic                      usr_ob_wr_o,
    output logic [DATA_W-1:0]         usr_ob_tlv_o,
    input  logic                      usr_ob_full_i,
    input  logic                      usr_ob_afull_i,
    output logic                      arb_busy_o,
    output logic [$clog2(N_REQ)-1:0]  arb_owner_o,
    output logic                      arb_error_o,
    output logic                      arb_tmo_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              arb_en_q;
    logic              wr_q;
    logic [DATA_W-1:0] tlv_q;
    logic              err_q;

    logic              issue_ok;
    logic              win_vld;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  sel;
    logic              issue;
    logic              sel_eot;
    logic              tmo_hit;
    logic              tmo;

    logic [DATA_W-1:0] req_word [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign req_word[g] = req_tlv_i[g*DATA_W +: DATA_W];
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Afull threshold leaves room for the one registered write still in flight.
    assign issue_ok = arb_en_q & ~usr_ob_afull_i;

    // First valid requester scanning upward from ptr with wrap.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
            if (!win_vld && req_vld_i[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel   = (state_q == StLocked) ? owner_q : win;
        issue = issue_ok & ((state_q == StLocked) ? req_vld_i[owner_q] : win_vld);
        sel_eot = req_eot_i[sel];
        req_rd_o = '0;
        if (issue) begin
            req_rd_o[sel] = 1'b1;
        end
    end

`ifdef CR_TLVP_OB_ARB_LOCK_TMO_EN
    localparam int unsigned CNT_W = $clog2(LOCK_TMO + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             afull_stall;

    // An owner that has data but is held off by afull is not considered stalled.
    assign afull_stall = arb_en_q & usr_ob_afull_i & req_vld_i[owner_q];
    assign tmo_hit     = (state_q == StLocked) & ~issue & (cnt_q == CNT_W'(LOCK_TMO));

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != StLocked) || issue || tmo_hit) begin
            cnt_d = '0;
        end else if (!afull_stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        tmo     = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    owner_d = win;
                    if (sel_eot) begin
                        ptr_d = next_idx(win);
                    end else begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                // An eot issue clears the timeout condition, so eot always wins.
                if (issue) begin
                    if (sel_eot) begin
                        state_d = StIdle;
                        ptr_d   = next_idx(owner_q);
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    ptr_d   = next_idx(owner_q);
                    tmo     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en_q <= 1'b0;
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            wr_q     <= 1'b0;
            tlv_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            arb_en_q <= 1'b1;
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            wr_q     <= issue;
            if (issue) begin
                tlv_q <= req_word[sel];
            end
            if (wr_q && usr_ob_full_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign usr_ob_wr_o  = wr_q;
    assign usr_ob_tlv_o = tlv_q;
    assign arb_busy_o   = (state_q == StLocked);
    assign arb_owner_o  = owner_q;
    assign arb_error_o  = err_q;
    assign arb_tmo_o    = tmo;

endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// Directed bench for cr_tlvp_ob_arb: requester FIFOs are modelled as queues, writes are logged
// and compared against hand-written expected word sequences.
module tb_cr_tlvp_ob_arb;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 64;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_eot;
    logic [N_REQ-1:0]        req_rd;
    logic [N_REQ*DATA_W-1:0] req_tlv;
    logic                    usr_ob_wr;
    logic [DATA_W-1:0]       usr_ob_tlv;
    logic                    usr_ob_full = 1'b0;
    logic                    usr_ob_afull = 1'b0;
    logic                    arb_busy;
    logic [1:0]              arb_owner;
    logic                    arb_error;
    logic                    arb_tmo;

    logic [63:0]      fq [N_REQ][$];
    logic [63:0]      obs_data [$];
    int               obs_cyc [$];
    logic [63:0]      exp_q [$];
    logic [N_REQ-1:0] rd_s;
    int               cyc_cnt = 0;
    int               n_chk = 0;
    int               n_pass = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    cr_tlvp_ob_arb #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .LOCK_TMO (8)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld_i      (req_vld),
        .req_tlv_i      (req_tlv),
        .req_eot_i      (req_eot),
        .req_rd_o       (req_rd),
        .usr_ob_wr_o    (usr_ob_wr),
        .usr_ob_tlv_o   (usr_ob_tlv),
        .usr_ob_full_i  (usr_ob_full),
        .usr_ob_afull_i (usr_ob_afull),
        .arb_busy_o     (arb_busy),
        .arb_owner_o    (arb_owner),
        .arb_error_o    (arb_error),
        .arb_tmo_o      (arb_tmo)
    );

    // Word encoding: bit 63 = eot, [7:4] = requester, [3:0] = word index.
    function automatic logic [63:0] w(input int r, input int i, input bit e);
        return {e, 55'd0, r[3:0], i[3:0]};
    endfunction

    task automatic drive();
        logic [63:0] h;
        for (int i = 0; i < N_REQ; i++) begin
            if (fq[i].size() > 0) begin
                h = fq[i][0];
                req_vld[i] = 1'b1;
                req_eot[i] = h[63];
                req_tlv[i*DATA_W +: DATA_W] = h;
            end else begin
                req_vld[i] = 1'b0;
                req_eot[i] = 1'b0;
                req_tlv[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    task automatic push1(input int r, input int i, input bit e);
        fq[r].push_back(w(r, i, e));
        drive();
    endtask

    task automatic push_tlv(input int r, input int n);
        for (int k = 0; k < n; k++) begin
            fq[r].push_back(w(r, k, k == n - 1));
        end
        drive();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares the write log with exp_q; writes after index first_contig must be back-to-back.
    task automatic check_seq(input string tag, input int first_contig);
        chk({tag, " count"}, obs_data.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_data.size()) begin
                chk({tag, " word"}, obs_data[k], exp_q[k]);
                if (k > first_contig) begin
                    chk({tag, " gap"}, obs_cyc[k] - obs_cyc[k-1], 1);
                end
            end
        end
        obs_data.delete();
        obs_cyc.delete();
    endtask

    // Requester FIFO model and write logger.
    initial begin
        forever begin
            @(negedge clk);
            rd_s = req_rd;
            @(posedge clk);
            #1;
            cyc_cnt++;
            if (usr_ob_wr) begin
                obs_data.push_back(usr_ob_tlv);
                obs_cyc.push_back(cyc_cnt);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (rd_s[i] && fq[i].size() > 0) begin
                    void'(fq[i].pop_front());
                end
            end
            drive();
        end
    end

    initial begin
        drive();
        cyc(2);

        // Reset state, with every requester already holding a 3-word TLV.
        for (int r = 0; r < N_REQ; r++) begin
            push_tlv(r, 3);
        end
        chk("rst wr", usr_ob_wr, 1'b0);
        chk("rst tlv", usr_ob_tlv, 64'd0);
        chk("rst rd", req_rd, 4'b0000);
        chk("rst busy", arb_busy, 1'b0);
        chk("rst owner", arb_owner, 2'd0);
        chk("rst error", arb_error, 1'b0);
        chk("rst tmo", arb_tmo, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("arb_en gate rd", req_rd, 4'b0000);

        // Round robin 0..3, 12 back-to-back writes.
        cyc(16);
        exp_q = '{w(0, 0, 0), w(0, 1, 0), w(0, 2, 1), w(1, 0, 0), w(1, 1, 0), w(1, 2, 1),
                  w(2, 0, 0), w(2, 1, 0), w(2, 2, 1), w(3, 0, 0), w(3, 1, 0), w(3, 2, 1)};
        check_seq("rr4", 0);
        chk("rr4 owner", arb_owner, 2'd3);
        chk("rr4 busy", arb_busy, 1'b0);

        // Requester 1 locked and starved; requester 2 must wait for its eot.
        push1(1, 0, 0);
        cyc(2);
        push_tlv(2, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lock rd", req_rd, 4'b0000);
        end
        chk("lock busy", arb_busy, 1'b1);
        chk("lock owner", arb_owner, 2'd1);
        chk("lock tmo", arb_tmo, 1'b0);
        cyc(1);
        push1(1, 1, 0);
        push1(1, 2, 1);
        cyc(10);
        exp_q = '{w(1, 0, 0), w(1, 1, 0), w(1, 2, 1), w(2, 0, 0), w(2, 1, 1)};
        check_seq("lock", 1);

        // Afull for 5 cycles mid-TLV.
        push_tlv(0, 6);
        cyc(2);
        usr_ob_afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("afull rd", req_rd, 4'b0000);
            chk("afull wr", usr_ob_wr, k == 0);
        end
        cyc(1);
        usr_ob_afull = 1'b0;
        cyc(8);
        exp_q = '{w(0, 0, 0), w(0, 1, 0), w(0, 2, 0), w(0, 3, 0), w(0, 4, 0), w(0, 5, 1)};
        check_seq("afull", 2);

        // Single-word TLVs on 0 and 3 with ptr=1: 3 first, never locked.
        push1(0, 9, 1);
        push1(3, 9, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single busy", arb_busy, 1'b0);
        end
        cyc(3);
        exp_q = '{w(3, 9, 1), w(0, 9, 1)};
        check_seq("single", 0);

        // Write while full sets a sticky error; reset mid-TLV clears everything.
        chk("err clear", arb_error, 1'b0);
        usr_ob_full = 1'b1;
        push1(2, 0, 0);
        push1(2, 1, 0);
        cyc(4);
        chk("err set", arb_error, 1'b1);
        usr_ob_full = 1'b0;
        cyc(3);
        chk("err sticky", arb_error, 1'b1);
        chk("mid busy", arb_busy, 1'b1);
        chk("mid owner", arb_owner, 2'd2);
        exp_q = '{w(2, 0, 0), w(2, 1, 0)};
        check_seq("err", 0);
        rst_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            fq[i].delete();
        end
        drive();
        #1;
        chk("rst2 error", arb_error, 1'b0);
        chk("rst2 busy", arb_busy, 1'b0);
        chk("rst2 owner", arb_owner, 2'd0);
        chk("rst2 wr", usr_ob_wr, 1'b0);
        chk("rst2 tlv", usr_ob_tlv, 64'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // ptr back to 0 after reset: requester 0 beats 3.
        push1(3, 7, 1);
        push1(0, 7, 1);
        cyc(5);
        exp_q = '{w(0, 7, 1), w(3, 7, 1)};
        check_seq("ptr rst", 0);

`ifdef CR_TLVP_OB_ARB_LOCK_TMO_EN
        // Owner 2 stalls after word 0; timeout after 9 cycles, then 3 is granted.
        push1(2, 0, 0);
        push1(3, 0, 1);
        @(negedge clk);
        chk("tmo grant2", req_rd, 4'b0100);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) begin
                chk("tmo pulse", arb_tmo, k == 9);
            end else begin
                chk("tmo grant3", req_rd, 4'b1000);
                chk("tmo busy", arb_busy, 1'b0);
                chk("tmo off", arb_tmo, 1'b0);
            end
        end
        cyc(3);
        exp_q = '{w(2, 0, 0), w(3, 0, 1)};
        check_seq("tmo", 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
